// File: rtl/game_control.sv
// game_control: frame sequencer for the bird game. Generates the frame tick,
// walks the datapath through erase/update/redraw/check once per frame,
// latches jump presses and runs the idle/play/game-over flow.
module game_control #(
  parameter int FRAME_DIV = 833334,
  parameter int CNT_W     = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       jump,
  input  logic       collide,
  input  logic       op_done,
  output logic [5:0] op,
  output logic       op_go,
  output logic       jump_now,
  output logic       playing,
  output logic       game_over,
  output logic [7:0] overrun_cnt
);

  localparam logic [5:0] OP_UPDATE_WALL    = 6'd0;
  localparam logic [5:0] OP_UPDATE_BIRD_Y  = 6'd1;
  localparam logic [5:0] OP_UPDATE_BIRD_VY = 6'd2;
  localparam logic [5:0] OP_DEL_WALL       = 6'd3;
  localparam logic [5:0] OP_DEL_BIRD       = 6'd4;
  localparam logic [5:0] OP_DRAW_WALL      = 6'd5;
  localparam logic [5:0] OP_DRAW_BIRD      = 6'd6;
  localparam logic [5:0] OP_INIT_GAME      = 6'd7;
  localparam logic [5:0] OP_NOP            = 6'd63;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_WAIT_TICK, S_DEL_WALL, S_DEL_BIRD, S_UPD_WALL,
    S_UPD_BIRD_Y, S_UPD_BIRD_VY, S_DRAW_WALL, S_DRAW_BIRD, S_CHECK, S_GAME_OVER
  } state_t;

  state_t           state, state_next;
  logic             entry;        // first cycle in the current state
  logic             start_q, jump_q;
  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic             tick_pending;
  logic             jump_latch;
  logic             start_rise, jump_rise;

  assign start_rise = start & ~start_q;
  assign jump_rise  = jump & ~jump_q;
  assign tick       = (cnt == CNT_LAST);

  // State register plus entry flag; entry gates op_go and op_done for
  // multi-cycle draw/erase states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      entry <= 1'b0;
    end else begin
      state <= state_next;
      entry <= (state_next != state);
    end
  end

  // Next-state and output decode; outputs depend on registered state only.
  always_comb begin
    state_next = state;
    op         = OP_NOP;
    op_go      = 1'b0;
    jump_now   = 1'b0;
    playing    = 1'b1;
    game_over  = 1'b0;
    case (state)
      S_IDLE: begin
        playing = 1'b0;
        if (start_rise) state_next = S_INIT;
      end
      S_INIT: begin
        op         = OP_INIT_GAME;
        op_go      = 1'b1;
        state_next = S_WAIT_TICK;
      end
      S_WAIT_TICK: begin
        if (tick_pending) state_next = S_DEL_WALL;
      end
      S_DEL_WALL: begin
        op    = OP_DEL_WALL;
        op_go = entry;
        if (!entry && op_done) state_next = S_DEL_BIRD;
      end
      S_DEL_BIRD: begin
        op    = OP_DEL_BIRD;
        op_go = entry;
        if (!entry && op_done) state_next = S_UPD_WALL;
      end
      S_UPD_WALL: begin
        op         = OP_UPDATE_WALL;
        op_go      = 1'b1;
        state_next = S_UPD_BIRD_Y;
      end
      S_UPD_BIRD_Y: begin
        op         = OP_UPDATE_BIRD_Y;
        op_go      = 1'b1;
        state_next = S_UPD_BIRD_VY;
      end
      S_UPD_BIRD_VY: begin
        op         = OP_UPDATE_BIRD_VY;
        op_go      = 1'b1;
        jump_now   = jump_latch;
        state_next = S_DRAW_WALL;
      end
      S_DRAW_WALL: begin
        op    = OP_DRAW_WALL;
        op_go = entry;
        if (!entry && op_done) state_next = S_DRAW_BIRD;
      end
      S_DRAW_BIRD: begin
        op    = OP_DRAW_BIRD;
        op_go = entry;
        if (!entry && op_done) state_next = S_CHECK;
      end
      S_CHECK: begin
        state_next = collide ? S_GAME_OVER : S_WAIT_TICK;
      end
      S_GAME_OVER: begin
        playing   = 1'b0;
        game_over = 1'b1;
        if (start_rise) state_next = S_INIT;
      end
      default: begin
        playing    = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

  // Button history; reset to 1 so a button held through reset does not fire.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q <= 1'b1;
      jump_q  <= 1'b1;
    end else begin
      start_q <= start;
      jump_q  <= jump;
    end
  end

  // Free-running frame divider.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CNT_W'(1);
  end

  // Pending frame tick and saturating overrun count. A tick landing on the
  // cycle WAIT_TICK consumes the previous one simply re-arms the flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_pending <= 1'b0;
      overrun_cnt  <= 8'd0;
    end else if (state == S_INIT) begin
      tick_pending <= 1'b0;
    end else if (state == S_WAIT_TICK && tick_pending) begin
      tick_pending <= tick;
    end else if (tick && playing) begin
      if (tick_pending && overrun_cnt != 8'hff) overrun_cnt <= overrun_cnt + 8'd1;
      tick_pending <= 1'b1;
    end
  end

  // Jump latch; consumed by UPD_BIRD_VY unless a fresh press lands that cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       jump_latch <= 1'b0;
    else if (state == S_INIT)        jump_latch <= 1'b0;
    else if (state == S_UPD_BIRD_VY) jump_latch <= jump_rise;
    else if (jump_rise && playing)   jump_latch <= 1'b1;
  end

endmodule

// File: tb/tb_game_control.sv
// tb_game_control: randomized stimulus against a frame-level reference model
// (mode + index into the per-frame op list), plus directed reset scenarios.
module tb_game_control;

  localparam int FDIV = 16;

  logic       clk = 1'b0;
  logic       reset, start, jump, collide, op_done;
  logic [5:0] op;
  logic       op_go, jump_now, playing, game_over;
  logic [7:0] overrun_cnt;

  game_control #(.FRAME_DIV(FDIV), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .jump(jump), .collide(collide),
    .op_done(op_done), .op(op), .op_go(op_go), .jump_now(jump_now),
    .playing(playing), .game_over(game_over), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_INIT = 1, M_WAIT = 2, M_SEQ = 3, M_CHK = 4, M_OVER = 5;
  int seq[7] = '{3, 4, 0, 1, 2, 5, 6};
  int m_mode, m_idx, m_age, m_cnt, m_ovr;
  bit m_pend, m_latch, m_ps, m_pj;

  function automatic bit is_multi(input int c);
    return c >= 3 && c <= 6;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_idx = 0; m_age = 0; m_cnt = 0; m_ovr = 0;
    m_pend = 0; m_latch = 0; m_ps = 1; m_pj = 1;
  endtask

  function automatic bit m_playing();
    return !(m_mode == M_IDLE || m_mode == M_OVER);
  endfunction

  function automatic logic [17:0] model_outs();
    int o; bit g, jn;
    o = 63; g = 0; jn = 0;
    if (m_mode == M_INIT) begin
      o = 7; g = 1;
    end else if (m_mode == M_SEQ) begin
      o  = seq[m_idx];
      g  = is_multi(o) ? (m_age == 0) : 1'b1;
      jn = (o == 2) && m_latch;
    end
    return {6'(o), g, jn, m_playing(), (m_mode == M_OVER), 8'(m_ovr)};
  endfunction

  task automatic model_step();
    bit srise, jrise, tick, pl, old_pend;
    int o;
    if (reset) begin model_reset(); return; end
    srise = start && !m_ps;
    jrise = jump && !m_pj;
    tick = (m_cnt == FDIV - 1);
    pl = m_playing();
    old_pend = m_pend;
    o = (m_mode == M_SEQ) ? seq[m_idx] : 63;
    if (m_mode == M_INIT) m_pend = 0;
    else if (m_mode == M_WAIT && m_pend) m_pend = tick;
    else if (tick && pl) begin
      if (m_pend && m_ovr < 255) m_ovr++;
      m_pend = 1;
    end
    if (m_mode == M_INIT) m_latch = 0;
    else if (o == 2) m_latch = jrise;
    else if (jrise && pl) m_latch = 1;
    case (m_mode)
      M_IDLE, M_OVER: if (srise) m_mode = M_INIT;
      M_INIT: m_mode = M_WAIT;
      M_WAIT: if (old_pend) begin m_mode = M_SEQ; m_idx = 0; m_age = 0; end
      M_SEQ: begin
        if (is_multi(o) && !(m_age > 0 && op_done)) m_age++;
        else if (m_idx == 6) m_mode = M_CHK;
        else begin m_idx++; m_age = 0; end
      end
      M_CHK: m_mode = collide ? M_OVER : M_WAIT;
      default: m_mode = M_IDLE;
    endcase
    m_cnt = (m_cnt + 1) % FDIV;
    m_ps = start;
    m_pj = jump;
  endtask

  function automatic logic [17:0] dut_outs();
    return {op, op_go, jump_now, playing, game_over, overrun_cnt};
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("outs", 32'(dut_outs()), 32'(model_outs()));
  endtask

  task automatic ensure_play();
    if (!m_playing()) begin
      start = 0; cyc();
      start = 1; cyc();
      start = 0;
    end
  endtask

  initial begin
    bit reached;
    reset = 1; start = 0; jump = 0; collide = 0; op_done = 0;
    model_reset();
    repeat (2) cyc();
    chk("reset_state", 32'(dut_outs()), {14'd0, 6'd63, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
    reset = 0;

    // randomized play
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) start = ~start;
      if ($urandom_range(0, 5) == 0) jump = ~jump;
      op_done = ($urandom_range(0, 2) == 0);
      collide = ($urandom_range(0, 15) == 0);
      cyc();
    end

    // stall a draw/erase op long enough to saturate the overrun counter
    collide = 0; op_done = 0;
    ensure_play();
    reached = 0;
    for (int i = 0; i < 300 && !reached; i++) begin
      cyc();
      reached = (m_mode == M_SEQ && m_age > 0);
    end
    chk("reach_stall", 32'(reached), 32'd1);
    for (int i = 0; i < 4400; i++) begin
      if ($urandom_range(0, 7) == 0) jump = ~jump;
      cyc();
    end
    chk("ovr_sat", 32'(overrun_cnt), 32'd255);
    for (int i = 0; i < 200; i++) begin
      op_done = ($urandom_range(0, 1) == 0);
      cyc();
    end

    // reset while DEL_BIRD waits for op_done
    collide = 0;
    ensure_play();
    reached = 0;
    for (int i = 0; i < 200 && !reached; i++) begin
      op_done = !(m_mode == M_SEQ && m_idx == 1);
      cyc();
      reached = (m_mode == M_SEQ && m_idx == 1 && m_age > 0);
    end
    chk("reach_del_bird", 32'(reached), 32'd1);
    op_done = 0;
    #3 reset = 1;
    #1;
    chk("rst_async_go", 32'(op_go), 32'd0);
    chk("rst_async_op", 32'(op), 32'd63);
    chk("rst_async_play", 32'(playing), 32'd0);
    chk("rst_async_ovr", 32'(overrun_cnt), 32'd0);
    model_reset();
    op_done = 1; cyc();
    op_done = 0; cyc();
    reset = 0;
    cyc();
    op_done = 1; cyc();
    op_done = 0;
    repeat (3) cyc();
    chk("late_done_idle", 32'(playing), 32'd0);

    // start held through reset release must not fire
    start = 1; reset = 1;
    repeat (2) cyc();
    reset = 0;
    repeat (5) cyc();
    chk("held_start_idle", 32'(playing), 32'd0);
    start = 0; cyc();
    start = 1; cyc();
    chk("init_op", 32'(op), 32'd7);
    chk("init_go", 32'(op_go), 32'd1);
    cyc();
    chk("wait_op", 32'(op), 32'd63);
    chk("wait_play", 32'(playing), 32'd1);
    start = 0;
    for (int i = 0; i < 400; i++) begin
      op_done = 1'b1;
      if ($urandom_range(0, 3) == 0) jump = ~jump;
      collide = ($urandom_range(0, 9) == 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_control.md
# game_control

Frame sequencer for the bird game. It generates the frame tick and steps the bird/wall datapath through one fixed operation sequence per frame: erase, update, redraw, collision check. It also latches jump presses and runs the idle/play/game-over flow. It sits between the board inputs (start, jump) and the datapath/plotter. It drives the datapath operation select and handshakes with the multi-cycle draw/erase operations.

## Interface
- FRAME_DIV, 833334: clk cycles per frame tick (50 MHz / 60 Hz); minimum legal value 2.
- CNT_W, 20: frame counter width; must satisfy 2^CNT_W ≥ FRAME_DIV.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; the block has one clock.
- start  in  1  start button, level, already synchronous to clk.
- jump  in  1  jump button, level, already synchronous to clk.
- collide  in  1  datapath collision flag, valid in CHECK.
- op_done  in  1  one-cycle pulse from datapath when a draw/erase op finishes.
- op  out  6  operation code: UPDATE_WALL=0, UPDATE_BIRD_Y=1, UPDATE_BIRD_VY=2, DEL_WALL=3, DEL_BIRD=4, DRAW_WALL=5, DRAW_BIRD=6, INIT_GAME=7, NOP=63.
- op_go  out  1  one-cycle pulse: start executing op.
- jump_now  out  1  valid with op_go for UPDATE_BIRD_VY; 1 = load jump velocity.
- playing  out  1  high in every state except IDLE and GAME_OVER.
- game_over  out  1  high only in GAME_OVER.
- overrun_cnt  out  8  saturating count of frame ticks lost while a tick was already pending.

## Operation
- States: IDLE, INIT, WAIT_TICK, DEL_WALL, DEL_BIRD, UPD_WALL, UPD_BIRD_Y, UPD_BIRD_VY, DRAW_WALL, DRAW_BIRD, CHECK, GAME_OVER.
- op output per state:
  - INIT: 7.
  - DEL_WALL: 3. DEL_BIRD: 4.
  - UPD_WALL: 0. UPD_BIRD_Y: 1. UPD_BIRD_VY: 2.
  - DRAW_WALL: 5. DRAW_BIRD: 6.
  - All other states: 63.
- IDLE: wait for a rising edge on start, then go to INIT.
- INIT: lasts 1 cycle; clears tick_pending and the jump latch; goes to WAIT_TICK.
- WAIT_TICK: when tick_pending=1, clear it and go to DEL_WALL.
- Frame sequence: DEL_WALL → DEL_BIRD → UPD_WALL → UPD_BIRD_Y → UPD_BIRD_VY → DRAW_WALL → DRAW_BIRD → CHECK.
- CHECK: lasts 1 cycle. collide=1 → GAME_OVER; otherwise → WAIT_TICK.
- GAME_OVER: wait for a rising edge on start, then go to INIT.
- Single-cycle ops (INIT, UPD_*): op_go=1 for the whole state, which lasts exactly 1 cycle.
- Multi-cycle ops (DEL_*, DRAW_*):
  - op_go=1 only in the entry cycle.
  - The state holds until op_done=1 is sampled in a later cycle.
  - op_done in the entry cycle, or in any non-draw state, is ignored.
- Edge detect: start_q and jump_q reset to 1, so a button held through reset release does not fire.
- Jump latch:
  - Set on any rising edge of jump while playing=1.
  - jump_now = latch value during UPD_BIRD_VY.
  - The latch clears at the end of UPD_BIRD_VY, unless a new rising edge occurs in that same cycle; then it stays set and applies to the next frame.
- Frame counter:
  - Free-running 0..FRAME_DIV-1, then wraps to 0.
  - tick = (count == FRAME_DIV-1).
- tick_pending:
  - Set by tick while playing=1.
  - If tick arrives while tick_pending is already 1 and not being consumed in that cycle, overrun_cnt increments, saturating at 255.
  - Tick in the same cycle WAIT_TICK consumes tick_pending: tick_pending stays 1, no overrun.
  - Ticks in IDLE/GAME_OVER are ignored.
- overrun_cnt clears only on reset.

## Timing
- Reset values:
  - State IDLE, op=63, op_go=0, jump_now=0, playing=0, game_over=0, overrun_cnt=0.
  - Counter=0, tick_pending=0, latch=0.
- Reset asserted mid-operation: outputs take reset values immediately (asynchronously); the in-flight op is abandoned and a later op_done is ignored.
- Rising edge of start sampled in cycle N → INIT in cycle N+1 → WAIT_TICK in cycle N+2.
- Frame latency, pending tick seen in WAIT_TICK at cycle T, zero-wait datapath (op_done one cycle after each op_go):
  - DEL_WALL T+1..T+2, DEL_BIRD T+3..T+4.
  - UPD_WALL T+5, UPD_BIRD_Y T+6, UPD_BIRD_VY T+7.
  - DRAW_WALL T+8..T+9, DRAW_BIRD T+10..T+11.
  - CHECK T+12; WAIT_TICK or GAME_OVER at T+13.
- Minimum frame: 12 cycles; FRAME_DIV below 13 guarantees overruns.
- All outputs are registered or decoded from state only; no combinational path from any input to any output.

## Test plan
- Reset, then hold start=1 through reset release: stays IDLE, no op_go. Then start 0→1: INIT (op=7, op_go=1) for 1 cycle, then WAIT_TICK.
- FRAME_DIV=16, op_done one cycle after each draw op_go, collide=0: op sequence 3,4,0,1,2,5,6 repeats every 16 cycles; overrun_cnt stays 0.
- Jump rising edge mid-frame: jump_now=1 at the next UPD_BIRD_VY and 0 on the following frame. Rising edge exactly during UPD_BIRD_VY: jump_now=0 that frame, 1 the next.
- Withhold op_done in DRAW_WALL for 40 cycles with FRAME_DIV=16: state holds with op_go low after the entry cycle; overrun_cnt reaches 1 after the second tick past the first. Force 300 overruns: saturates at 255.
- collide=1 in CHECK: next cycle GAME_OVER, game_over=1, playing=0, op=63; ticks ignored. start edge → INIT → new frames.
- Assert reset while in DEL_BIRD waiting for op_done: op_go=0 and IDLE immediately; a late op_done pulse causes no transition.
